// File: rtl/qpsk_frame_sync_if.sv
// Symbol-in / byte-out bus for the QPSK frame synchroniser.
// master: symbol producer and byte consumer (testbench or upstream glue).
// slave:  the frame synchroniser itself.
interface qpsk_frame_sync_if;
  logic        sym_valid;
  logic        i_bit;
  logic        q_bit;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        frame_start;
  logic        frame_end;
  logic        locked;
  logic [15:0] frame_cnt;

  modport master (
    output sym_valid, i_bit, q_bit,
    input  byte_out, byte_valid, frame_start, frame_end, locked, frame_cnt
  );

  modport slave (
    input  sym_valid, i_bit, q_bit,
    output byte_out, byte_valid, frame_start, frame_end, locked, frame_cnt
  );
endinterface

// File: rtl/qpsk_frame_sync.sv
// QPSK frame synchroniser.
// Serialises hard-decided symbols (I bit first), hunts for a sync word with
// a bounded Hamming distance at either bit alignment inside a symbol, then
// packs a fixed number of payload bytes MSB-first and returns to the hunt.
module qpsk_frame_sync #(
  parameter int unsigned          SYNC_LEN      = 16,
  parameter logic [SYNC_LEN-1:0]  SYNC_WORD     = 16'h1ACF,
  parameter int unsigned          PAYLOAD_BYTES = 8,
  parameter int unsigned          MAX_ERR       = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  qpsk_frame_sync_if.slave         bus
);

  localparam int unsigned FILL_W = $clog2(SYNC_LEN + 1) + 1;
  localparam int unsigned DIST_W = $clog2(SYNC_LEN + 1);
  localparam logic [FILL_W-1:0] SYNC_LEN_F = FILL_W'(SYNC_LEN);
  localparam logic [DIST_W-1:0] MAX_ERR_D  =
    DIST_W'((MAX_ERR > SYNC_LEN) ? SYNC_LEN : MAX_ERR);
  localparam logic [7:0] LAST_IDX = 8'(PAYLOAD_BYTES - 1);

  typedef enum logic [0:0] {
    ST_SEARCH  = 1'b0,
    ST_PAYLOAD = 1'b1
  } state_t;

  // Number of positions where the two words differ.
  function automatic logic [DIST_W-1:0] hamming(
    input logic [SYNC_LEN-1:0] a,
    input logic [SYNC_LEN-1:0] b
  );
    logic [DIST_W-1:0] cnt;
    cnt = '0;
    for (int k = 0; k < int'(SYNC_LEN); k++) begin
      cnt = cnt + {{(DIST_W-1){1'b0}}, a[k] ^ b[k]};
    end
    return cnt;
  endfunction

  // State and datapath registers
  state_t              state_r;
  logic [SYNC_LEN-1:0] sr_r;
  logic [FILL_W-1:0]   fill_r;
  logic [7:0]          acc_r;
  logic [2:0]          bit_cnt_r;
  logic [7:0]          byte_idx_r;
  logic [7:0]          byte_out_r;
  logic                byte_valid_r;
  logic                frame_start_r;
  logic                frame_end_r;
  logic                locked_r;
  logic [15:0]         frame_cnt_r;

  // Next-state values
  state_t              state_s;
  logic [SYNC_LEN-1:0] sr_s;
  logic [FILL_W-1:0]   fill_s;
  logic [7:0]          acc_s;
  logic [2:0]          bit_cnt_s;
  logic [7:0]          byte_idx_s;
  logic [7:0]          byte_out_s;
  logic                byte_valid_s;
  logic                frame_start_s;
  logic                frame_end_s;
  logic                locked_s;
  logic [15:0]         frame_cnt_s;

  // Sync search: window ending on the I bit (A) and on the Q bit (B)
  logic [SYNC_LEN-1:0] form_a_s;
  logic [SYNC_LEN-1:0] form_b_s;
  logic                match_a_s;
  logic                match_b_s;

  assign form_a_s  = {sr_r[SYNC_LEN-2:0], bus.i_bit};
  assign form_b_s  = {sr_r[SYNC_LEN-3:0], bus.i_bit, bus.q_bit};
  assign match_a_s = ((fill_r + FILL_W'(1)) >= SYNC_LEN_F) &&
                     (hamming(form_a_s, SYNC_WORD) <= MAX_ERR_D);
  assign match_b_s = ((fill_r + FILL_W'(2)) >= SYNC_LEN_F) &&
                     (hamming(form_b_s, SYNC_WORD) <= MAX_ERR_D);

  // Byte assembler: the I bit is shifted first, then the Q bit
  logic       done_i_s;
  logic       done_q_s;
  logic [7:0] acc_i_s;
  logic [7:0] acc_q_s;
  logic [2:0] cnt_i_s;
  logic       last_s;

  assign done_i_s = (bit_cnt_r == 3'd7);
  assign acc_i_s  = {acc_r[6:0], bus.i_bit};
  assign cnt_i_s  = bit_cnt_r + 3'd1;
  assign done_q_s = !done_i_s && (cnt_i_s == 3'd7);
  assign acc_q_s  = {acc_i_s[6:0], bus.q_bit};
  assign last_s   = (byte_idx_r == LAST_IDX);

  // Next-state and output decode for the SEARCH/PAYLOAD controller
  always_comb begin
    state_s       = state_r;
    sr_s          = sr_r;
    fill_s        = fill_r;
    acc_s         = acc_r;
    bit_cnt_s     = bit_cnt_r;
    byte_idx_s    = byte_idx_r;
    byte_out_s    = byte_out_r;
    byte_valid_s  = 1'b0;
    frame_start_s = 1'b0;
    frame_end_s   = 1'b0;
    locked_s      = locked_r;
    frame_cnt_s   = frame_cnt_r;
    if (bus.sym_valid) begin
      case (state_r)
        ST_SEARCH: begin
          if (match_a_s) begin
            // Sync ended on the I bit; Q is the first payload bit.
            state_s    = ST_PAYLOAD;
            locked_s   = 1'b1;
            acc_s      = {7'd0, bus.q_bit};
            bit_cnt_s  = 3'd1;
            byte_idx_s = 8'd0;
          end else if (match_b_s) begin
            state_s    = ST_PAYLOAD;
            locked_s   = 1'b1;
            acc_s      = 8'd0;
            bit_cnt_s  = 3'd0;
            byte_idx_s = 8'd0;
          end else begin
            sr_s   = form_b_s;
            fill_s = ((fill_r + FILL_W'(2)) >= SYNC_LEN_F) ? SYNC_LEN_F
                                                           : fill_r + FILL_W'(2);
          end
        end
        ST_PAYLOAD: begin
          if (done_i_s || done_q_s) begin
            byte_valid_s  = 1'b1;
            byte_out_s    = done_i_s ? acc_i_s : acc_q_s;
            frame_start_s = (byte_idx_r == 8'd0);
            if (last_s) begin
              // Frame complete; a leftover Q bit seeds the next search.
              frame_end_s = 1'b1;
              frame_cnt_s = frame_cnt_r + 16'd1;
              locked_s    = 1'b0;
              state_s     = ST_SEARCH;
              acc_s       = 8'd0;
              bit_cnt_s   = 3'd0;
              byte_idx_s  = 8'd0;
              if (done_i_s) begin
                sr_s   = {{(SYNC_LEN-1){1'b0}}, bus.q_bit};
                fill_s = FILL_W'(1);
              end else begin
                sr_s   = '0;
                fill_s = '0;
              end
            end else begin
              byte_idx_s = byte_idx_r + 8'd1;
              if (done_i_s) begin
                acc_s     = {7'd0, bus.q_bit};
                bit_cnt_s = 3'd1;
              end else begin
                acc_s     = 8'd0;
                bit_cnt_s = 3'd0;
              end
            end
          end else begin
            acc_s     = acc_q_s;
            bit_cnt_s = cnt_i_s + 3'd1;
          end
        end
        default: begin
          state_s  = ST_SEARCH;
          sr_s     = '0;
          fill_s   = '0;
          locked_s = 1'b0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Register all state and outputs; reset clears everything at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_SEARCH;
      sr_r          <= '0;
      fill_r        <= '0;
      acc_r         <= 8'd0;
      bit_cnt_r     <= 3'd0;
      byte_idx_r    <= 8'd0;
      byte_out_r    <= 8'd0;
      byte_valid_r  <= 1'b0;
      frame_start_r <= 1'b0;
      frame_end_r   <= 1'b0;
      locked_r      <= 1'b0;
      frame_cnt_r   <= 16'd0;
    end else begin
      state_r       <= state_s;
      sr_r          <= sr_s;
      fill_r        <= fill_s;
      acc_r         <= acc_s;
      bit_cnt_r     <= bit_cnt_s;
      byte_idx_r    <= byte_idx_s;
      byte_out_r    <= byte_out_s;
      byte_valid_r  <= byte_valid_s;
      frame_start_r <= frame_start_s;
      frame_end_r   <= frame_end_s;
      locked_r      <= locked_s;
      frame_cnt_r   <= frame_cnt_s;
    end
  end

  assign bus.byte_out    = byte_out_r;
  assign bus.byte_valid  = byte_valid_r;
  assign bus.frame_start = frame_start_r;
  assign bus.frame_end   = frame_end_r;
  assign bus.locked      = locked_r;
  assign bus.frame_cnt   = frame_cnt_r;

endmodule

// File: tb/tb_qpsk_frame_sync.sv
// Testbench for qpsk_frame_sync: three instances (default, MAX_ERR=16,
// PAYLOAD_BYTES=2) driven from one directed sequence plus random streams,
// checked against a bit-serial reference model of the framing rules.
module tb_qpsk_frame_sync;
  localparam logic [15:0] SYNC = 16'h1ACF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  qpsk_frame_sync_if bus0();
  qpsk_frame_sync_if bus1();
  qpsk_frame_sync_if bus2();

  qpsk_frame_sync #(.SYNC_LEN(16), .SYNC_WORD(16'h1ACF), .PAYLOAD_BYTES(8), .MAX_ERR(1))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  qpsk_frame_sync #(.SYNC_LEN(16), .SYNC_WORD(16'h1ACF), .PAYLOAD_BYTES(8), .MAX_ERR(16))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  qpsk_frame_sync #(.SYNC_LEN(16), .SYNC_WORD(16'h1ACF), .PAYLOAD_BYTES(2), .MAX_ERR(1))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  int tests = 0;
  int fails = 0;
  int pb[3] = '{8, 8, 2};
  int me[3] = '{1, 16, 1};

  // Reference model: bit history while hunting, byte assembly while locked
  bit          m_lock[3];
  logic [15:0] m_hist[3];
  int          m_hlen[3];
  logic [7:0]  m_acc[3];
  int          m_nb[3];
  int          m_idx[3];
  logic [15:0] m_fcnt[3];

  bit         bq[$];
  int         bv_seen;
  int         fe_seen;
  logic [7:0] byte_log[$];

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < 3; n++) begin
      m_lock[n] = 1'b0; m_hist[n] = 16'd0; m_hlen[n] = 0;
      m_acc[n] = 8'd0; m_nb[n] = 0; m_idx[n] = 0; m_fcnt[n] = 16'd0;
    end
  endtask

  task automatic model_sym(input int n, input logic i, input logic q,
                           output logic bv, output logic [7:0] bo,
                           output logic fs, output logic fe);
    logic b;
    bv = 1'b0; bo = 8'd0; fs = 1'b0; fe = 1'b0;
    for (int k = 0; k < 2; k++) begin
      b = (k == 0) ? i : q;
      if (!m_lock[n]) begin
        m_hist[n] = {m_hist[n][14:0], b};
        m_hlen[n]++;
        if (m_hlen[n] >= 16 && $countones(m_hist[n] ^ SYNC) <= me[n]) begin
          m_lock[n] = 1'b1; m_nb[n] = 0; m_idx[n] = 0;
        end
      end else begin
        m_acc[n] = {m_acc[n][6:0], b};
        m_nb[n]++;
        if (m_nb[n] == 8) begin
          bv = 1'b1; bo = m_acc[n];
          fs = (m_idx[n] == 0); fe = (m_idx[n] == pb[n] - 1);
          m_nb[n] = 0;
          if (fe) begin
            m_fcnt[n] = m_fcnt[n] + 16'd1;
            m_lock[n] = 1'b0; m_hist[n] = 16'd0; m_hlen[n] = 0;
          end else begin
            m_idx[n]++;
          end
        end
      end
    end
  endtask

  task automatic get_out(input int n, output logic bv, output logic fs, output logic fe,
                         output logic lk, output logic [7:0] bo, output logic [15:0] fc);
    case (n)
      0: begin bv = bus0.byte_valid; fs = bus0.frame_start; fe = bus0.frame_end;
               lk = bus0.locked; bo = bus0.byte_out; fc = bus0.frame_cnt; end
      1: begin bv = bus1.byte_valid; fs = bus1.frame_start; fe = bus1.frame_end;
               lk = bus1.locked; bo = bus1.byte_out; fc = bus1.frame_cnt; end
      default: begin bv = bus2.byte_valid; fs = bus2.frame_start; fe = bus2.frame_end;
               lk = bus2.locked; bo = bus2.byte_out; fc = bus2.frame_cnt; end
    endcase
  endtask

  task automatic drive(input int n, input logic v, input logic i, input logic q);
    bus0.sym_valid = 1'b0; bus0.i_bit = 1'b0; bus0.q_bit = 1'b0;
    bus1.sym_valid = 1'b0; bus1.i_bit = 1'b0; bus1.q_bit = 1'b0;
    bus2.sym_valid = 1'b0; bus2.i_bit = 1'b0; bus2.q_bit = 1'b0;
    case (n)
      0: begin bus0.sym_valid = v; bus0.i_bit = i; bus0.q_bit = q; end
      1: begin bus1.sym_valid = v; bus1.i_bit = i; bus1.q_bit = q; end
      default: begin bus2.sym_valid = v; bus2.i_bit = i; bus2.q_bit = q; end
    endcase
  endtask

  task automatic check_inst(input int n, input logic ebv, input logic [7:0] ebo,
                            input logic efs, input logic efe);
    logic bv, fs, fe, lk;
    logic [7:0] bo;
    logic [15:0] fc;
    get_out(n, bv, fs, fe, lk, bo, fc);
    chk("byte_valid", {15'd0, bv}, {15'd0, ebv});
    chk("frame_start", {15'd0, fs}, {15'd0, efs});
    chk("frame_end", {15'd0, fe}, {15'd0, efe});
    chk("locked", {15'd0, lk}, {15'd0, m_lock[n]});
    chk("frame_cnt", fc, m_fcnt[n]);
    if (ebv) chk("byte_out", {8'd0, bo}, {8'd0, ebo});
    if (bv) begin bv_seen++; byte_log.push_back(bo); end
    if (fe) fe_seen++;
  endtask

  // One symbol into instance n, checked one clock later
  task automatic sym(input int n, input logic i, input logic q);
    logic ebv, efs, efe;
    logic [7:0] ebo;
    @(negedge clk);
    drive(n, 1'b1, i, q);
    model_sym(n, i, q, ebv, ebo, efs, efe);
    @(posedge clk); #1;
    check_inst(n, ebv, ebo, efs, efe);
  endtask

  task automatic idle();
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    for (int n = 0; n < 3; n++) check_inst(n, 1'b0, 8'd0, 1'b0, 1'b0);
  endtask

  task automatic push_word(input logic [31:0] w, input int nb);
    for (int k = nb - 1; k >= 0; k--) bq.push_back(w[k]);
  endtask

  task automatic send_queue(input int n);
    logic i, q;
    if (bq.size() % 2 == 1) bq.push_back(1'b0);
    while (bq.size() >= 2) begin
      i = bq.pop_front();
      q = bq.pop_front();
      sym(n, i, q);
    end
  endtask

  task automatic do_reset();
    logic bv, fs, fe, lk;
    logic [7:0] bo;
    logic [15:0] fc;
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    for (int n = 0; n < 3; n++) begin
      get_out(n, bv, fs, fe, lk, bo, fc);
      chk("rst_byte_valid", {15'd0, bv}, 16'd0);
      chk("rst_frame_start", {15'd0, fs}, 16'd0);
      chk("rst_frame_end", {15'd0, fe}, 16'd0);
      chk("rst_locked", {15'd0, lk}, 16'd0);
      chk("rst_byte_out", {8'd0, bo}, 16'd0);
      chk("rst_frame_cnt", fc, 16'd0);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic clear_log();
    bv_seen = 0; fe_seen = 0; byte_log.delete();
  endtask

  task automatic random_frames(input int n, input int frames);
    logic [15:0] w;
    int e;
    for (int f = 0; f < frames; f++) begin
      for (int g = $urandom_range(0, 5); g > 0; g--) bq.push_back($urandom_range(0, 1) == 1);
      w = SYNC;
      e = $urandom_range(0, 3);
      if (e >= 2) w[$urandom_range(0, 15)] ^= 1'b1;
      if (e == 3) w[$urandom_range(0, 15)] ^= 1'b1;
      push_word({16'd0, w}, 16);
      for (int b = 0; b < pb[n] * 8; b++) bq.push_back($urandom_range(0, 1) == 1);
    end
    send_queue(n);
    idle();
  endtask

  logic bv_o, fs_o, fe_o, lk_o;
  logic [7:0] bo_o;
  logic [15:0] fc_o;
  logic [7:0] exp_b2b[4] = '{8'h55, 8'hAA, 8'h12, 8'h34};

  initial begin
    drive(0, 1'b0, 1'b0, 1'b0);
    model_reset();
    do_reset();

    // Aligned exact sync, eight 0xC3 bytes
    clear_log();
    push_word({16'd0, SYNC}, 16);
    for (int k = 0; k < 8; k++) push_word(32'hC3, 8);
    send_queue(0);
    idle();
    chk("aligned_count", 16'(bv_seen), 16'd8);
    for (int k = 0; k < byte_log.size(); k++) chk("aligned_byte", {8'd0, byte_log[k]}, 16'h00C3);
    get_out(0, bv_o, fs_o, fe_o, lk_o, bo_o, fc_o);
    chk("aligned_frame_cnt", fc_o, 16'd1);
    chk("aligned_unlocked", {15'd0, lk_o}, 16'd0);

    // Odd alignment: one extra leading bit, sync ends on an I bit
    clear_log();
    bq.push_back(1'b1);
    push_word({16'd0, SYNC}, 16);
    for (int k = 0; k < 8; k++) push_word(32'hC3, 8);
    send_queue(0);
    idle();
    chk("odd_count", 16'(bv_seen), 16'd8);
    if (byte_log.size() > 0) chk("odd_first_byte", {8'd0, byte_log[0]}, 16'h00C3);
    get_out(0, bv_o, fs_o, fe_o, lk_o, bo_o, fc_o);
    chk("odd_frame_cnt", fc_o, 16'd2);

    // One flipped bit still locks
    clear_log();
    push_word(32'h1ACE, 16);
    for (int k = 0; k < 8; k++) push_word(32'h5A, 8);
    send_queue(0);
    idle();
    chk("err1_count", 16'(bv_seen), 16'd8);

    // Two flipped bits never lock
    clear_log();
    push_word(32'h1ACC, 16);
    push_word(32'h0, 16);
    send_queue(0);
    idle();
    chk("err2_no_bytes", 16'(bv_seen), 16'd0);
    get_out(0, bv_o, fs_o, fe_o, lk_o, bo_o, fc_o);
    chk("err2_unlocked", {15'd0, lk_o}, 16'd0);

    // Fill guard with MAX_ERR=16: no lock before 16 bits, lock on symbol 8
    do_reset();
    for (int k = 0; k < 7; k++) begin
      sym(1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      get_out(1, bv_o, fs_o, fe_o, lk_o, bo_o, fc_o);
      chk("fill_guard_unlocked", {15'd0, lk_o}, 16'd0);
    end
    sym(1, 1'b1, 1'b0);
    get_out(1, bv_o, fs_o, fe_o, lk_o, bo_o, fc_o);
    chk("fill_guard_lock", {15'd0, lk_o}, 16'd1);
    for (int k = 0; k < 32; k++) bq.push_back($urandom_range(0, 1) == 1);
    for (int k = 0; k < 32; k++) bq.push_back($urandom_range(0, 1) == 1);
    send_queue(1);
    idle();
    get_out(1, bv_o, fs_o, fe_o, lk_o, bo_o, fc_o);
    chk("fill_guard_frame_cnt", fc_o, 16'd1);

    // Back-to-back two-byte frames with no gap
    clear_log();
    push_word({16'd0, SYNC}, 16);
    push_word(32'h55AA, 16);
    push_word({16'd0, SYNC}, 16);
    push_word(32'h1234, 16);
    send_queue(2);
    idle();
    chk("b2b_count", 16'(bv_seen), 16'd4);
    chk("b2b_frame_ends", 16'(fe_seen), 16'd2);
    for (int k = 0; k < 4 && k < byte_log.size(); k++)
      chk("b2b_byte", {8'd0, byte_log[k]}, {8'd0, exp_b2b[k]});
    get_out(2, bv_o, fs_o, fe_o, lk_o, bo_o, fc_o);
    chk("b2b_frame_cnt", fc_o, 16'd2);

    // Reset after three bytes, then a clean frame
    do_reset();
    clear_log();
    push_word({16'd0, SYNC}, 16);
    push_word(32'h112233, 24);
    push_word(32'h1, 2);
    send_queue(0);
    chk("midrst_bytes", 16'(bv_seen), 16'd3);
    do_reset();
    chk("midrst_no_frame_end", 16'(fe_seen), 16'd0);
    push_word({16'd0, SYNC}, 16);
    for (int k = 0; k < 8; k++) push_word($urandom_range(0, 255), 8);
    send_queue(0);
    idle();
    get_out(0, bv_o, fs_o, fe_o, lk_o, bo_o, fc_o);
    chk("midrst_frame_cnt", fc_o, 16'd1);

    // Random streams with near-sync words at random bit offsets
    for (int n = 0; n < 3; n++) random_frames(n, 6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
